dmem_arbiter: RTL and testbench
===============================

Name: dmem_arbiter

Overview:
Two-requester arbiter and sequencer for the single-port data memory RAM (synchronous, 1-cycle read, index = word address).
- Port 0 (cpu) is the multicycle core's MEM stage.
- Port 1 (dma) is the host/loader that fills and drains matrix operands around a program run.
- Round-robin fairness, an optional DMA burst lock, per-port read-data routing and stall/transfer performance counters.

Parameters:
ADDR_W, 32, word-index width driven to the RAM
DATA_W, 32, data width
CNT_W, 32, width of performance counters (saturating)

Ports:
CLOCK_50  in  1  system clock
rstn  in  1  reset (synchronous, active-low)
cpu_req  in  1  cpu access request, held until granted
cpu_we  in  1  1 = write, 0 = read
cpu_addr  in  ADDR_W  word index
cpu_wdata  in  DATA_W  write data
cpu_gnt  out  1  combinational accept; transfer occurs when cpu_req & cpu_gnt
cpu_rvalid  out  1  read data valid pulse
cpu_rdata  out  DATA_W  read data
dma_req, dma_we, dma_addr, dma_wdata  in  as cpu_*
dma_lock  in  1  sampled on an accepted dma transfer; 1 = keep ownership for next transfer
dma_gnt, dma_rvalid, dma_rdata  out  as cpu_*
mem_wr_en  out  1  RAM write enable
mem_index  out  ADDR_W  RAM index
mem_entry  out  DATA_W  RAM write data
mem_entry_out  in  DATA_W  RAM read data, valid the cycle after index presented
cpu_stall_cnt  out  CNT_W  cycles with cpu_req & !cpu_gnt
dma_xfer_cnt  out  CNT_W  accepted dma transfers

Behaviour:
- Reset values (synchronous, rstn = 0 at posedge):
  - state = ARB, last_gnt = dma (so cpu wins first tie).
  - All rvalid = 0, rdata = 0, counters = 0.
  - During reset cycles, gnt = 0 and mem_wr_en = 0.
- FSM states: ARB, LOCK.
  - ARB, one requester: grant it.
  - ARB, both requesting: grant the port not granted last; last_gnt updates on every accepted transfer.
  - ARB → LOCK: accepted dma transfer with dma_lock = 1.
  - LOCK: dma_gnt = dma_req, cpu_gnt = 0.
  - LOCK → ARB: accepted dma transfer with dma_lock = 0, or any cycle with dma_req = 0. The cpu may be granted the cycle after exit.
  - LOCK is never held across a cycle with dma_req low, so dma cannot starve the cpu by idling.
- Grants: at most one gnt high per cycle. gnt is combinational from state, last_gnt and the req inputs, with no dependence on we/addr.
- RAM drive: mem_index, mem_entry and mem_wr_en are combinational from the granted port.
  - mem_wr_en = granted_we & accepted.
  - With no grant: mem_wr_en = 0; mem_index/mem_entry hold the last granted values (no X-propagation).
- Read latency:
  - A read accepted in cycle t gives rvalid = 1 for exactly cycle t+1 on the owning port, with rdata = mem_entry_out.
  - A 1-bit owner tag plus a pending flag are registered at t. rdata holds its value after rvalid falls.
- Writes: complete at the acceptance edge; no rvalid.
- Back-to-back: a new transfer may be accepted every cycle, including a read in t and a read on the other port in t+1. Tag routing must keep them separate.
- Read-after-write, same address, consecutive cycles: the read returns the new data (RAM write-first ordering is required of the memory; the arbiter adds no bypass).
- Counters:
  - cpu_stall_cnt increments on cpu_req & !cpu_gnt.
  - dma_xfer_cnt increments on dma_req & dma_gnt.
  - Both saturate at all-ones with no wrap.
- Reset mid-read: a pending rvalid is discarded; no rvalid in the cycle after reset deasserts.
- Requests are not cancelled by the arbiter. A requester dropping req before grant is legal and simply withdraws.

Decomposition:
- Shared package dmem_arb_pkg:
  - state encoding (ARB = 0, LOCK = 1)
  - port IDs (PORT_CPU = 0, PORT_DMA = 1)
  - default widths
- One natural sub-module, rr_arb2: the 2-way round-robin grant function with last_gnt register and a force-port input for LOCK. The FSM, read-tag pipeline and counters stay in dmem_arbiter.

Test Plan:
- cpu read only, addr 5, RAM[5] = 0x1234 → cpu_gnt same cycle, cpu_rvalid exactly 1 cycle later with 0x1234, dma_rvalid stays 0.
- Both req reads every cycle for 6 cycles after reset → grants alternate cpu, dma, cpu, dma, cpu, dma; cpu_stall_cnt = 3.
- dma write burst addr 10..13 with dma_lock = 1,1,1,0 while cpu_req held → cpu_gnt = 0 for 4 cycles, granted on 5th, RAM[10..13] written, dma_xfer_cnt = 4.
- cpu write 0xDEAD to addr 7 then dma read addr 7 next cycle → dma_rvalid with 0xDEAD, owner routing correct.
- Read accepted, rstn low next cycle, then released → no rvalid on either port, counters = 0, state ARB.
- Preload cpu_stall_cnt near all-ones (CNT_W = 4 build), stall 20 cycles → saturates at 15.

Source files
------------

// File: rtl/dmem_arb_pkg.sv
// Shared definitions for the data-memory arbiter: FSM encoding, port IDs and default widths.
package dmem_arb_pkg;
   typedef enum logic {ARB = 1'b0, LOCK = 1'b1} arb_state_t;

   localparam logic PORT_CPU = 1'b0;
   localparam logic PORT_DMA = 1'b1;

   localparam int DEF_ADDR_W = 32;
   localparam int DEF_DATA_W = 32;
   localparam int DEF_CNT_W  = 32;
endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant, combinational from req/last_gnt; force_dma hands the RAM to dma only.
// Zero-latency grant; a requester not granted simply waits (req held), last_gnt moves on each accept.
module rr_arb2 import dmem_arb_pkg::*; (
   input  logic CLOCK_50,
   input  logic rstn,
   input  logic cpu_req,
   input  logic dma_req,
   input  logic force_dma,
   output logic cpu_gnt,
   output logic dma_gnt
);
   logic last_gnt;

   always_comb begin
      cpu_gnt = 1'b0;
      dma_gnt = 1'b0;
      if (rstn) begin
         if (force_dma) begin
            dma_gnt = dma_req;
         end else if (cpu_req && dma_req) begin
            cpu_gnt = (last_gnt == PORT_DMA);
            dma_gnt = (last_gnt == PORT_CPU);
         end else begin
            cpu_gnt = cpu_req;
            dma_gnt = dma_req;
         end
      end
   end

   // Reset to dma so the cpu wins the first tie.
   always_ff @(posedge CLOCK_50) begin
      if (!rstn)
         last_gnt <= PORT_DMA;
      else if (cpu_gnt || dma_gnt)
         last_gnt <= dma_gnt ? PORT_DMA : PORT_CPU;
   end
endmodule

// File: rtl/dmem_arbiter.sv
// cpu/dma arbiter for the single-port data RAM with dma burst lock and read-data routing.
// Grant is same-cycle; read data returns one cycle after accept; ungranted requesters stall.
module dmem_arbiter import dmem_arb_pkg::*; #(
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int DATA_W = DEF_DATA_W,
   parameter int CNT_W  = DEF_CNT_W
) (
   input  logic              CLOCK_50,
   input  logic              rstn,
   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   output logic              cpu_gnt,
   output logic              cpu_rvalid,
   output logic [DATA_W-1:0] cpu_rdata,
   input  logic              dma_req,
   input  logic              dma_we,
   input  logic [ADDR_W-1:0] dma_addr,
   input  logic [DATA_W-1:0] dma_wdata,
   input  logic              dma_lock,
   output logic              dma_gnt,
   output logic              dma_rvalid,
   output logic [DATA_W-1:0] dma_rdata,
   output logic              mem_wr_en,
   output logic [ADDR_W-1:0] mem_index,
   output logic [DATA_W-1:0] mem_entry,
   input  logic [DATA_W-1:0] mem_entry_out,
   output logic [CNT_W-1:0]  cpu_stall_cnt,
   output logic [CNT_W-1:0]  dma_xfer_cnt
);
   localparam logic [CNT_W-1:0] CNT_ONE = 1;

   arb_state_t        state_q, state_d;
   logic              accepted;
   logic              g_we;
   logic [ADDR_W-1:0] g_addr, idx_q;
   logic [DATA_W-1:0] g_wdata, entry_q;
   logic              pend_q, tag_q;
   logic [DATA_W-1:0] cpu_rdata_q, dma_rdata_q;

   rr_arb2 u_rr (
      .CLOCK_50  (CLOCK_50),
      .rstn      (rstn),
      .cpu_req   (cpu_req),
      .dma_req   (dma_req),
      .force_dma (state_q == LOCK),
      .cpu_gnt   (cpu_gnt),
      .dma_gnt   (dma_gnt)
   );

   always_comb begin
      state_d = state_q;
      case (state_q)
         ARB:  if (dma_gnt && dma_lock) state_d = LOCK;
         LOCK: if (!dma_req || (dma_gnt && !dma_lock)) state_d = ARB;
         default: state_d = ARB;
      endcase
   end

   always_ff @(posedge CLOCK_50) begin
      if (!rstn) state_q <= ARB;
      else       state_q <= state_d;
   end

   assign accepted = cpu_gnt | dma_gnt;
   assign g_we     = dma_gnt ? dma_we    : cpu_we;
   assign g_addr   = dma_gnt ? dma_addr  : cpu_addr;
   assign g_wdata  = dma_gnt ? dma_wdata : cpu_wdata;

   // Without a grant the RAM sees the last granted index/data, never raw request inputs.
   assign mem_wr_en = accepted & g_we;
   assign mem_index = accepted ? g_addr  : idx_q;
   assign mem_entry = accepted ? g_wdata : entry_q;

   always_ff @(posedge CLOCK_50) begin
      if (!rstn) begin
         idx_q   <= '0;
         entry_q <= '0;
         pend_q  <= 1'b0;
         tag_q   <= PORT_CPU;
      end else begin
         pend_q <= accepted & ~g_we;
         if (accepted) begin
            idx_q   <= g_addr;
            entry_q <= g_wdata;
            tag_q   <= dma_gnt ? PORT_DMA : PORT_CPU;
         end
      end
   end

   // Gated with rstn so a read accepted just before reset never surfaces.
   assign cpu_rvalid = rstn & pend_q & (tag_q == PORT_CPU);
   assign dma_rvalid = rstn & pend_q & (tag_q == PORT_DMA);
   assign cpu_rdata  = cpu_rvalid ? mem_entry_out : cpu_rdata_q;
   assign dma_rdata  = dma_rvalid ? mem_entry_out : dma_rdata_q;

   always_ff @(posedge CLOCK_50) begin
      if (!rstn) begin
         cpu_rdata_q   <= '0;
         dma_rdata_q   <= '0;
         cpu_stall_cnt <= '0;
         dma_xfer_cnt  <= '0;
      end else begin
         if (cpu_rvalid) cpu_rdata_q <= mem_entry_out;
         if (dma_rvalid) dma_rdata_q <= mem_entry_out;
         if (cpu_req && !cpu_gnt && cpu_stall_cnt != '1)
            cpu_stall_cnt <= cpu_stall_cnt + CNT_ONE;
         if (dma_req && dma_gnt && dma_xfer_cnt != '1)
            dma_xfer_cnt <= dma_xfer_cnt + CNT_ONE;
      end
   end
endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed vector bench for dmem_arbiter against a write-first behavioural RAM.
module tb_dmem_arbiter;
   localparam int AW = 6;
   localparam int DW = 32;
   localparam int CW = 4;

   logic          CLOCK_50 = 1'b0;
   logic          rstn;
   logic          cpu_req, cpu_we, dma_req, dma_we, dma_lock;
   logic [AW-1:0] cpu_addr, dma_addr;
   logic [DW-1:0] cpu_wdata, dma_wdata;
   logic          cpu_gnt, cpu_rvalid, dma_gnt, dma_rvalid, mem_wr_en;
   logic [DW-1:0] cpu_rdata, dma_rdata, mem_entry, mem_entry_out;
   logic [AW-1:0] mem_index;
   logic [CW-1:0] cpu_stall_cnt, dma_xfer_cnt;

   logic [DW-1:0] ram [64];

   int checks = 0;
   int errors = 0;

   always #10 CLOCK_50 = ~CLOCK_50;

   dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .CNT_W(CW)) dut (
      .CLOCK_50      (CLOCK_50),
      .rstn          (rstn),
      .cpu_req       (cpu_req),
      .cpu_we        (cpu_we),
      .cpu_addr      (cpu_addr),
      .cpu_wdata     (cpu_wdata),
      .cpu_gnt       (cpu_gnt),
      .cpu_rvalid    (cpu_rvalid),
      .cpu_rdata     (cpu_rdata),
      .dma_req       (dma_req),
      .dma_we        (dma_we),
      .dma_addr      (dma_addr),
      .dma_wdata     (dma_wdata),
      .dma_lock      (dma_lock),
      .dma_gnt       (dma_gnt),
      .dma_rvalid    (dma_rvalid),
      .dma_rdata     (dma_rdata),
      .mem_wr_en     (mem_wr_en),
      .mem_index     (mem_index),
      .mem_entry     (mem_entry),
      .mem_entry_out (mem_entry_out),
      .cpu_stall_cnt (cpu_stall_cnt),
      .dma_xfer_cnt  (dma_xfer_cnt)
   );

   // Write-first synchronous RAM, one-cycle read.
   always @(posedge CLOCK_50) begin
      if (mem_wr_en) begin
         ram[mem_index] <= mem_entry;
         mem_entry_out  <= mem_entry;
      end else begin
         mem_entry_out  <= ram[mem_index];
      end
   end

   typedef struct {
      logic          c_req, c_we;
      logic [AW-1:0] c_addr;
      logic [DW-1:0] c_wd;
      logic          d_req, d_we;
      logic [AW-1:0] d_addr;
      logic [DW-1:0] d_wd;
      logic          d_lock;
      logic          e_cg, e_dg, e_we;
      logic [AW-1:0] e_idx;
      logic          e_crv, e_drv;
      logic [DW-1:0] e_crd, e_drd;
      logic [CW-1:0] e_stall, e_xfer;
   } vec_t;

   vec_t vq[$];

   function automatic vec_t mk(
      input logic c_req, c_we, input logic [AW-1:0] c_addr, input logic [DW-1:0] c_wd,
      input logic d_req, d_we, input logic [AW-1:0] d_addr, input logic [DW-1:0] d_wd,
      input logic d_lock,
      input logic e_cg, e_dg, e_we, input logic [AW-1:0] e_idx,
      input logic e_crv, e_drv, input logic [DW-1:0] e_crd, e_drd,
      input logic [CW-1:0] e_stall, e_xfer);
      vec_t v;
      v.c_req = c_req; v.c_we = c_we; v.c_addr = c_addr; v.c_wd = c_wd;
      v.d_req = d_req; v.d_we = d_we; v.d_addr = d_addr; v.d_wd = d_wd; v.d_lock = d_lock;
      v.e_cg = e_cg; v.e_dg = e_dg; v.e_we = e_we; v.e_idx = e_idx;
      v.e_crv = e_crv; v.e_drv = e_drv; v.e_crd = e_crd; v.e_drd = e_drd;
      v.e_stall = e_stall; v.e_xfer = e_xfer;
      return v;
   endfunction

   task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic drive(input vec_t v);
      cpu_req = v.c_req; cpu_we = v.c_we; cpu_addr = v.c_addr; cpu_wdata = v.c_wd;
      dma_req = v.d_req; dma_we = v.d_we; dma_addr = v.d_addr; dma_wdata = v.d_wd;
      dma_lock = v.d_lock;
   endtask

   task automatic idle();
      cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
      dma_req = 0; dma_we = 0; dma_addr = '0; dma_wdata = '0; dma_lock = 0;
   endtask

   initial begin
      for (int i = 0; i < 64; i++) ram[i] = 32'hA000 + i;
      ram[5] = 32'h1234;
      mem_entry_out = '0;
      idle();
      rstn = 1'b0;

      // Round-robin alternation after reset (cpu first).
      vq.push_back(mk(1,0,20,0, 1,0,30,0,0, 1,0,0,20, 0,0, 0,0, 0,0));
      vq.push_back(mk(1,0,21,0, 1,0,31,0,0, 0,1,0,31, 1,0, 32'hA014,0, 0,0));
      vq.push_back(mk(1,0,22,0, 1,0,32,0,0, 1,0,0,22, 0,1, 32'hA014,32'hA01F, 1,1));
      vq.push_back(mk(1,0,23,0, 1,0,33,0,0, 0,1,0,33, 1,0, 32'hA016,32'hA01F, 1,1));
      vq.push_back(mk(1,0,24,0, 1,0,34,0,0, 1,0,0,24, 0,1, 32'hA016,32'hA021, 2,2));
      vq.push_back(mk(1,0,25,0, 1,0,35,0,0, 0,1,0,35, 1,0, 32'hA018,32'hA021, 2,2));
      vq.push_back(mk(0,0,0,0,  0,0,0,0,0,  0,0,0,35, 0,1, 32'hA018,32'hA023, 3,3));
      // cpu single read of addr 5.
      vq.push_back(mk(1,0,5,0,  0,0,0,0,0,  1,0,0,5,  0,0, 32'hA018,32'hA023, 3,3));
      vq.push_back(mk(0,0,0,0,  0,0,0,0,0,  0,0,0,5,  1,0, 32'h1234,32'hA023, 3,3));
      // dma locked write burst 10..13 while cpu waits.
      vq.push_back(mk(1,0,9,0, 1,1,10,32'hBEEF000A,1, 0,1,1,10, 0,0, 32'h1234,32'hA023, 3,3));
      vq.push_back(mk(1,0,9,0, 1,1,11,32'hBEEF000B,1, 0,1,1,11, 0,0, 32'h1234,32'hA023, 4,4));
      vq.push_back(mk(1,0,9,0, 1,1,12,32'hBEEF000C,1, 0,1,1,12, 0,0, 32'h1234,32'hA023, 5,5));
      vq.push_back(mk(1,0,9,0, 1,1,13,32'hBEEF000D,0, 0,1,1,13, 0,0, 32'h1234,32'hA023, 6,6));
      vq.push_back(mk(1,0,9,0, 0,0,0,0,0,  1,0,0,9,  0,0, 32'h1234,32'hA023, 7,7));
      vq.push_back(mk(0,0,0,0, 0,0,0,0,0,  0,0,0,9,  1,0, 32'hA009,32'hA023, 7,7));
      // cpu write then dma read of the same address.
      vq.push_back(mk(1,1,7,32'hDEAD, 0,0,0,0,0, 1,0,1,7, 0,0, 32'hA009,32'hA023, 7,7));
      vq.push_back(mk(0,0,0,0, 1,0,7,0,0,  0,1,0,7,  0,0, 32'hA009,32'hA023, 7,7));
      vq.push_back(mk(0,0,0,0, 0,0,0,0,0,  0,0,0,7,  0,1, 32'hA009,32'hDEAD, 7,8));
      // Lock released by dma idling; cpu blocked that cycle, granted the next.
      vq.push_back(mk(0,0,0,0, 1,0,40,0,1, 0,1,0,40, 0,0, 32'hA009,32'hDEAD, 7,8));
      vq.push_back(mk(1,0,41,0, 0,0,0,0,0, 0,0,0,40, 0,1, 32'hA009,32'hA028, 7,9));
      vq.push_back(mk(1,0,41,0, 0,0,0,0,0, 1,0,0,41, 0,0, 32'hA009,32'hA028, 8,9));
      vq.push_back(mk(0,0,0,0, 0,0,0,0,0,  0,0,0,41, 1,0, 32'hA029,32'hA028, 8,9));

      // Reset state, with a request present to show grants are held off.
      repeat (2) @(posedge CLOCK_50);
      @(negedge CLOCK_50);
      cpu_req = 1; cpu_we = 1;
      #1;
      chk("rst cpu_gnt", cpu_gnt, 0);
      chk("rst mem_wr_en", mem_wr_en, 0);
      chk("rst rvalid", {cpu_rvalid, dma_rvalid}, 0);
      chk("rst counters", {cpu_stall_cnt, dma_xfer_cnt}, 0);
      idle();
      @(negedge CLOCK_50);
      rstn = 1'b1;

      foreach (vq[i]) begin
         drive(vq[i]);
         #1;
         chk($sformatf("v%0d cpu_gnt", i),    cpu_gnt,       vq[i].e_cg);
         chk($sformatf("v%0d dma_gnt", i),    dma_gnt,       vq[i].e_dg);
         chk($sformatf("v%0d mem_wr_en", i),  mem_wr_en,     vq[i].e_we);
         chk($sformatf("v%0d mem_index", i),  mem_index,     vq[i].e_idx);
         chk($sformatf("v%0d cpu_rvalid", i), cpu_rvalid,    vq[i].e_crv);
         chk($sformatf("v%0d dma_rvalid", i), dma_rvalid,    vq[i].e_drv);
         chk($sformatf("v%0d cpu_rdata", i),  cpu_rdata,     vq[i].e_crd);
         chk($sformatf("v%0d dma_rdata", i),  dma_rdata,     vq[i].e_drd);
         chk($sformatf("v%0d stall_cnt", i),  cpu_stall_cnt, vq[i].e_stall);
         chk($sformatf("v%0d xfer_cnt", i),   dma_xfer_cnt,  vq[i].e_xfer);
         @(negedge CLOCK_50);
      end
      idle();
      for (int a = 10; a < 14; a++)
         chk($sformatf("ram[%0d]", a), ram[a], 32'hBEEF0000 + a);
      chk("ram[7]", ram[7], 32'hDEAD);

      // Reset while a read is pending.
      cpu_req = 1; cpu_addr = 5;
      #1 chk("pre-rst cpu_gnt", cpu_gnt, 1);
      @(negedge CLOCK_50);
      rstn = 1'b0; idle();
      #1 chk("mid-rst cpu_rvalid", cpu_rvalid, 0);
      @(negedge CLOCK_50);
      rstn = 1'b1;
      #1;
      chk("post-rst rvalid", {cpu_rvalid, dma_rvalid}, 0);
      chk("post-rst counters", {cpu_stall_cnt, dma_xfer_cnt}, 0);
      chk("post-rst cpu_rdata", cpu_rdata, 0);
      cpu_req = 1; dma_req = 1; dma_lock = 1; cpu_addr = 1; dma_addr = 2;
      #1;
      chk("post-rst tie cpu_gnt", cpu_gnt, 1);
      chk("post-rst tie dma_gnt", dma_gnt, 0);

      // Long locked dma stream: both counters must stick at all-ones.
      repeat (24) @(negedge CLOCK_50);
      #1;
      chk("lock cpu_gnt", cpu_gnt, 0);
      chk("sat stall_cnt", cpu_stall_cnt, 4'hF);
      chk("sat xfer_cnt", dma_xfer_cnt, 4'hF);
      idle();
      @(negedge CLOCK_50);
      #1 chk("held stall_cnt", cpu_stall_cnt, 4'hF);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
